// File: rtl/normalizer_left_shifter.sv
// Normalizing left shifter for a floating-point adder datapath.
// Two-stage valid/ready pipeline: stage 1 captures the operand and its
// leading-zero count, stage 2 holds the shifted, rounding-ready result.
// Optional build macro: NORMALIZER_DENORMAL_CLAMP_EN limits the shift so the
// exponent never drops below 1, producing a subnormal encoding instead.

module normalizer_left_shifter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [9:0]  in_exponent,
    input  logic [47:0] in_mantissa,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sign,
    output logic [9:0]  out_exponent,
    output logic [23:0] out_mantissa,
    output logic        out_guard,
    output logic        out_round,
    output logic        out_sticky,
    output logic        out_zero
);

    // Stage 1 registers
    logic        r_s1_valid;
    logic        r_s1_sign;
    logic [9:0]  r_s1_exp;
    logic [47:0] r_s1_mant;
    logic [5:0]  r_s1_lzc;

    // Stage 2 registers
    logic        r_s2_valid;
    logic        r_s2_sign;
    logic [9:0]  r_s2_exp;
    logic [23:0] r_s2_mant;
    logic        r_s2_guard;
    logic        r_s2_round;
    logic        r_s2_sticky;
    logic        r_s2_zero;

    logic        w_s1_adv;
    logic        w_in_fire;
    logic [5:0]  w_lzc;
    logic [5:0]  w_shift;
    logic [47:0] w_shifted;
    logic [9:0]  w_exp_nxt;
    logic        w_zero;
`ifdef NORMALIZER_DENORMAL_CLAMP_EN
    logic [10:0] w_exp_m1;
    logic [10:0] w_lim;
`endif

    // Handshake: stage 1 moves on whenever stage 2 is empty or draining
    always_comb begin
        w_s1_adv  = !r_s2_valid || out_ready;
        in_ready  = !r_s1_valid || w_s1_adv;
        w_in_fire = in_valid && in_ready;
    end

    // Leading-zero count of the incoming mantissa; highest set bit wins
    always_comb begin
        w_lzc = 6'd48;
        for (int i = 0; i < 48; i++) begin
            if (in_mantissa[i]) begin
                w_lzc = 6'(47 - i);
            end
        end
    end

    // Shift amount selection; the clamp keeps the exponent at 1 or above
    always_comb begin
`ifdef NORMALIZER_DENORMAL_CLAMP_EN
        w_exp_m1 = {r_s1_exp[9], r_s1_exp} - 11'd1;
        w_lim    = w_exp_m1[10] ? 11'd0 : w_exp_m1;
        w_shift  = ({5'd0, r_s1_lzc} < w_lim) ? r_s1_lzc : w_lim[5:0];
`else
        w_shift  = r_s1_lzc;
`endif
    end

    // Shifted mantissa and adjusted exponent for the stage 2 register
    always_comb begin
        w_zero    = (r_s1_lzc == 6'd48);
        w_shifted = r_s1_mant << w_shift;
        w_exp_nxt = r_s1_exp - {4'd0, w_shift};
`ifdef NORMALIZER_DENORMAL_CLAMP_EN
        // Hidden bit not reached: encode as subnormal
        if (!w_shifted[47]) begin
            w_exp_nxt = 10'd0;
        end
`endif
        if (w_zero) begin
            w_shifted = 48'd0;
            w_exp_nxt = 10'd0;
        end
    end

    // Stage valid flags; synchronous reset discards in-flight items
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (in_ready) begin
                r_s1_valid <= in_valid;
            end
            if (w_s1_adv) begin
                r_s2_valid <= r_s1_valid;
            end
        end
    end

    // Stage 1 data capture on an accepted input
    always_ff @(posedge clk) begin
        if (w_in_fire) begin
            r_s1_sign <= in_sign;
            r_s1_exp  <= in_exponent;
            r_s1_mant <= in_mantissa;
            r_s1_lzc  <= w_lzc;
        end
    end

    // Stage 2 data capture when stage 1 holds an item and may advance
    always_ff @(posedge clk) begin
        if (w_s1_adv && r_s1_valid) begin
            r_s2_sign   <= r_s1_sign;
            r_s2_exp    <= w_exp_nxt;
            r_s2_mant   <= w_shifted[47:24];
            r_s2_guard  <= w_shifted[23];
            r_s2_round  <= w_shifted[22];
            r_s2_sticky <= |w_shifted[21:0];
            r_s2_zero   <= w_zero;
        end
    end

    // Output drive straight from stage 2
    always_comb begin
        out_valid    = r_s2_valid;
        out_sign     = r_s2_sign;
        out_exponent = r_s2_exp;
        out_mantissa = r_s2_mant;
        out_guard    = r_s2_guard;
        out_round    = r_s2_round;
        out_sticky   = r_s2_sticky;
        out_zero     = r_s2_zero;
    end

endmodule

// File: tb/tb_normalizer_left_shifter.sv
// Self-checking bench for normalizer_left_shifter with a scoreboard model.
// Honors NORMALIZER_DENORMAL_CLAMP_EN the same way the design does.

module tb_normalizer_left_shifter;

    typedef struct packed {
        logic        sign;
        logic [9:0]  exp;
        logic [23:0] mant;
        logic        g;
        logic        r;
        logic        s;
        logic        z;
    } res_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_sign = 1'b0;
    logic [9:0]  in_exponent = 10'd0;
    logic [47:0] in_mantissa = 48'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_sign;
    logic [9:0]  out_exponent;
    logic [23:0] out_mantissa;
    logic        out_guard;
    logic        out_round;
    logic        out_sticky;
    logic        out_zero;

    int   n_checks = 0;
    int   n_errors = 0;
    int   mode = 0;
    res_t q[$];

    normalizer_left_shifter dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sign      (in_sign),
        .in_exponent  (in_exponent),
        .in_mantissa  (in_mantissa),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sign     (out_sign),
        .out_exponent (out_exponent),
        .out_mantissa (out_mantissa),
        .out_guard    (out_guard),
        .out_round    (out_round),
        .out_sticky   (out_sticky),
        .out_zero     (out_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference: normalize by plain arithmetic
    function automatic res_t model(input logic s, input logic [9:0] e, input logic [47:0] m);
        res_t        r;
        int          lzc;
        int          sh;
        logic [47:0] sft;
`ifdef NORMALIZER_DENORMAL_CLAMP_EN
        int          ei;
        int          lim;
`endif
        r = '0;
        r.sign = s;
        if (m == 48'd0) begin
            r.z = 1'b1;
            return r;
        end
        lzc = 0;
        while (!m[47 - lzc]) lzc++;
`ifdef NORMALIZER_DENORMAL_CLAMP_EN
        ei  = int'($signed(e));
        lim = (ei - 1 > 0) ? ei - 1 : 0;
        sh  = (lzc < lim) ? lzc : lim;
`else
        sh  = lzc;
`endif
        sft    = m << sh;
        r.mant = sft[47:24];
        r.g    = sft[23];
        r.r    = sft[22];
        r.s    = |sft[21:0];
        r.exp  = e - 10'(sh);
`ifdef NORMALIZER_DENORMAL_CLAMP_EN
        if (!sft[47]) r.exp = 10'd0;
`endif
        return r;
    endfunction

    // Scoreboard: compare every meaningful cycle, sampled on the falling edge
    always @(negedge clk) begin
        res_t got;
        if (!reset_n) begin
            q.delete();
        end else begin
            chk("in_ready", 64'(in_ready), 64'(!(q.size() == 2 && !out_ready)));
            if (q.size() == 2) chk("out_valid_full", 64'(out_valid), 64'd1);
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("spurious_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    got = {out_sign, out_exponent, out_mantissa, out_guard, out_round,
                           out_sticky, out_zero};
                    chk("out_data", 64'(got), 64'(q[0]));
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (in_valid && in_ready) q.push_back(model(in_sign, in_exponent, in_mantissa));
        end
    end

    // Downstream ready generator
    initial begin
        logic [3:0] pat;
        int         k;
        pat = 4'b1001;
        k = 0;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0: out_ready = 1'b1;
                1: begin
                    out_ready = pat[3 - (k % 4)];
                    k++;
                end
                2: out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Present one item and hold it until accepted; called at posedge+1
    task automatic send(input logic s, input logic [9:0] e, input logic [47:0] m);
        bit ok;
        ok = 1'b0;
        in_valid    = 1'b1;
        in_sign     = s;
        in_exponent = e;
        in_mantissa = m;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int t;
        mode = 0;
        in_valid = 1'b0;
        t = 0;
        while (q.size() != 0 && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain", 64'(q.size()), 64'd0);
    endtask

    initial begin
        res_t        r;
        res_t        got;
        int          lat;
        logic [47:0] m;
        logic [9:0]  e;

        // Reset and post-reset state
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Hand-computed pins for the model
        r = model(1'b0, 10'd127, 48'h800000_000000);
        chk("pin_norm", 64'(r), 64'({1'b0, 10'd127, 24'h800000, 4'b0000}));
        // bit24 -> 47, bit23 -> 46, bit0 -> 23 (guard)
        r = model(1'b0, 10'd127, 48'h000001_800001);
        chk("pin_lzc23", 64'(r), 64'({1'b0, 10'd104, 24'hC00000, 4'b1000}));
        r = model(1'b1, 10'd77, 48'd0);
        chk("pin_zero", 64'(r), 64'({1'b1, 10'd0, 24'h000000, 4'b0001}));
        r = model(1'b0, 10'd5, 48'h000100_000000);
`ifdef NORMALIZER_DENORMAL_CLAMP_EN
        chk("pin_clamp", 64'(r), 64'({1'b0, 10'd0, 24'h001000, 4'b0000}));
`else
        chk("pin_clamp", 64'(r), 64'({1'b0, 10'h3F6, 24'h800000, 4'b0000}));
`endif

        // Latency of a single normalized item
        mode = 0;
        in_valid = 1'b1;
        in_sign = 1'b0;
        in_exponent = 10'd127;
        in_mantissa = 48'h800000_000000;
        @(negedge clk);
        chk("lat_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            #1;
            lat++;
        end
        got = {out_sign, out_exponent, out_mantissa, out_guard, out_round, out_sticky, out_zero};
        chk("latency", 64'(lat), 64'd2);
        chk("lat_data", 64'(got), 64'({1'b0, 10'd127, 24'h800000, 4'b0000}));
        @(posedge clk);
        #1;

        // Directed corner items through the scoreboard
        send(1'b0, 10'd127, 48'h000001_800001);
        send(1'b1, 10'd33, 48'd0);
        send(1'b0, 10'd5, 48'h000100_000000);
        send(1'b1, 10'd1, 48'h400000_000000);
        send(1'b0, 10'h3F0, 48'h000000_000001);
        drain();

        // Back-to-back with out_ready pattern 1,0,0,1
        mode = 1;
        for (int i = 0; i < 8; i++) begin
            send(1'($urandom_range(0, 1)), 10'($urandom), {$urandom, $urandom} >> (i * 5));
        end
        drain();

        // Randomized traffic with random backpressure
        mode = 2;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            m = 48'({$urandom, $urandom}) >> $urandom_range(0, 48);
            e = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 20)) : 10'($urandom);
            send(1'($urandom_range(0, 1)), e, m);
        end
        drain();

        // Reset with two items in flight
        mode = 3;
        idle(1);
        send(1'b0, 10'd100, 48'h123456_789ABC);
        send(1'b1, 10'd50, 48'h000FFF_000000);
        in_valid = 1'b0;
        @(negedge clk);
        chk("inflight_full", 64'(q.size()), 64'd2);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        mode = 0;
        @(negedge clk);
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        chk("midreset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        idle(6);

        // Traffic resumes cleanly after reset
        send(1'b0, 10'd127, 48'h800000_000000);
        send(1'b1, 10'd9, 48'h000000_0000FF);
        drain();
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
